// File: rtl/cmp_pkg.sv
// Shared encoding for the magnitude comparator: mode field width, mode codes
// and the function that turns "less than" and "equal" into a mode result.
package cmp_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    CMP_LT = 3'd0,
    CMP_LE = 3'd1,
    CMP_EQ = 3'd2,
    CMP_NE = 3'd3,
    CMP_GT = 3'd4,
    CMP_GE = 3'd5
  } cmp_mode_e;

  // Codes 6 and 7 are reserved and always evaluate false.
  function automatic logic cmp_eval(input logic [MODE_W-1:0] mode,
                                    input logic lt, input logic eq);
    logic res;
    unique case (mode)
      CMP_LT:  res = lt;
      CMP_LE:  res = lt | eq;
      CMP_EQ:  res = eq;
      CMP_NE:  res = ~eq;
      CMP_GT:  res = ~(lt | eq);
      CMP_GE:  res = ~lt;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mag_compare_filt_if.sv
// Sample/result bundle of mag_compare_filt. With CMP_SIGNED_EN defined the
// is_signed qualifier is added to the sample side.
interface mag_compare_filt_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic              in_valid;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [MODE_W-1:0] mode;
`ifdef CMP_SIGNED_EN
  logic              is_signed;
`endif
  logic              raw_q;
  logic              raw_valid;
  logic              stable;
  logic              rise;
  logic [7:0]        run_cnt;

  modport master (
    output in_valid, a, b, mode,
`ifdef CMP_SIGNED_EN
    output is_signed,
`endif
    input  raw_q, raw_valid, stable, rise, run_cnt
  );

  modport slave (
    input  in_valid, a, b, mode,
`ifdef CMP_SIGNED_EN
    input  is_signed,
`endif
    output raw_q, raw_valid, stable, rise, run_cnt
  );

endinterface

// File: rtl/stab_counter.sv
// Saturating run counter: counts consecutive true samples up to STABLE_CYCLES,
// flags stable at saturation and pulses rise on the 0->1 transition of stable.
module stab_counter #(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid_i,
  input  logic       sample_i,
  input  logic       clear_i,
  output logic [7:0] count_o,
  output logic       stable_o,
  output logic       rise_o
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [7:0] cnt_q, cnt_d;
  logic       stable_q, stable_d;
  logic       rise_q, rise_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (sample_valid_i) begin
      if (clear_i || !sample_i) begin
        cnt_d = '0;
      end else if (cnt_q != STABLE_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    stable_d = (cnt_d == STABLE_MAX);
    rise_d   = stable_d & ~stable_q;
  end

  // NOTE: reset here is synchronous: rst is only looked at on the rising clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign count_o  = cnt_q;
  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/mag_compare_filt.sv
// Registered magnitude compare followed by a run-length stability filter.
// Optional macro CMP_SIGNED_EN adds two's-complement compares via is_signed.
module mag_compare_filt
  import cmp_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 3
) (
  input logic                 clk,
  input logic                 rst,
  mag_compare_filt_if.slave   bus
);

  logic [WIDTH-1:0]  a_k, b_k;
  logic              a_lt_b, a_eq_b;
  logic              result_d, mode_chg_d;

  logic              result_q;
  logic              raw_valid_q;
  logic              clear_q;
  logic [MODE_W-1:0] prev_mode_q;

`ifdef CMP_SIGNED_EN
  logic              prev_signed_q;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign a_k        = bus.a ^ {bus.is_signed, {(WIDTH-1){1'b0}}};
  assign b_k        = bus.b ^ {bus.is_signed, {(WIDTH-1){1'b0}}};
  assign mode_chg_d = (bus.mode != prev_mode_q) || (bus.is_signed != prev_signed_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_signed_q <= 1'b0;
    end else if (bus.in_valid) begin
      prev_signed_q <= bus.is_signed;
    end
  end
`else
  assign a_k        = bus.a;
  assign b_k        = bus.b;
  assign mode_chg_d = (bus.mode != prev_mode_q);
`endif

  assign a_lt_b   = (a_k < b_k);
  assign a_eq_b   = (bus.a == bus.b);
  assign result_d = cmp_eval(bus.mode, a_lt_b, a_eq_b);

  // clear_q rides with the sample so the counter drops the run on a mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= 1'b0;
      raw_valid_q <= 1'b0;
      clear_q     <= 1'b0;
      prev_mode_q <= '0;
    end else begin
      raw_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q    <= result_d;
        clear_q     <= mode_chg_d;
        prev_mode_q <= bus.mode;
      end
    end
  end

  stab_counter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab_counter (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (raw_valid_q),
    .sample_i       (result_q),
    .clear_i        (clear_q),
    .count_o        (bus.run_cnt),
    .stable_o       (bus.stable),
    .rise_o         (bus.rise)
  );

  assign bus.raw_q     = result_q;
  assign bus.raw_valid = raw_valid_q;

endmodule

// File: tb/tb_mag_compare_filt.sv
// Directed bench for mag_compare_filt (WIDTH=8, STABLE_CYCLES=3) with
// hand-computed expectations; signed cases run only when CMP_SIGNED_EN is set.
module tb_mag_compare_filt;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mag_compare_filt_if #(.WIDTH(8)) bus_if ();

  mag_compare_filt #(
    .WIDTH         (8),
    .STABLE_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    bus_if.in_valid = 1'b1;
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.mode     = m;
  endtask

  task automatic idle();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_raw_q"},     bus_if.raw_q,     0);
    check({tag, "_raw_valid"}, bus_if.raw_valid, 0);
    check({tag, "_run_cnt"},   bus_if.run_cnt,   0);
    check({tag, "_stable"},    bus_if.stable,    0);
    check({tag, "_rise"},      bus_if.rise,      0);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.a        = '0;
    bus_if.b        = '0;
    bus_if.mode     = CMP_LT;
`ifdef CMP_SIGNED_EN
    bus_if.is_signed = 1'b0;
`endif

    // Reset state, and a sample presented during reset is discarded
    tick(); tick();
    check_all_zero("reset");
    send(8'd3, 8'd7, CMP_LT);
    tick();
    check("rst_discard_raw_q", bus_if.raw_q, 0);
    check("rst_discard_valid", bus_if.raw_valid, 0);
    rst = 1'b0;
    idle();
    tick();

    // LT 3<7 three times -> stable after the 4th edge
    send(8'd3, 8'd7, CMP_LT);
    tick();
    check("lt_e1_raw_q", bus_if.raw_q, 1);
    check("lt_e1_raw_valid", bus_if.raw_valid, 1);
    check("lt_e1_run_cnt", bus_if.run_cnt, 0);
    tick();
    check("lt_e2_run_cnt", bus_if.run_cnt, 1);
    tick();
    check("lt_e3_run_cnt", bus_if.run_cnt, 2);
    check("lt_e3_stable", bus_if.stable, 0);
    idle();
    tick();
    check("lt_e4_run_cnt", bus_if.run_cnt, 3);
    check("lt_e4_stable", bus_if.stable, 1);
    check("lt_e4_rise", bus_if.rise, 1);
    check("lt_e4_raw_valid", bus_if.raw_valid, 0);
    tick();
    check("lt_e5_rise_once", bus_if.rise, 0);
    check("lt_e5_stable", bus_if.stable, 1);

    // Saturating extra true sample, then a false one breaks the run
    send(8'd3, 8'd7, CMP_LT);
    tick();
    send(8'd9, 8'd7, CMP_LT);
    tick();
    check("false_raw_q", bus_if.raw_q, 0);
    check("sat_run_cnt", bus_if.run_cnt, 3);
    check("sat_no_rise", bus_if.rise, 0);
    idle();
    tick();
    check("false_run_cnt", bus_if.run_cnt, 0);
    check("false_stable", bus_if.stable, 0);
    check("false_rise", bus_if.rise, 0);

    // EQ at 255 twice, then GE: each mode change restarts the run
    send(8'd255, 8'd255, CMP_EQ);
    tick();
    check("eq_raw_q", bus_if.raw_q, 1);
    tick();
    check("eq_chg_run_cnt", bus_if.run_cnt, 0);
    send(8'd255, 8'd255, CMP_GE);
    tick();
    check("eq_second_run_cnt", bus_if.run_cnt, 1);
    tick();
    check("ge_chg_run_cnt", bus_if.run_cnt, 0);
    tick();
    check("ge_1_run_cnt", bus_if.run_cnt, 1);
    tick();
    check("ge_2_run_cnt", bus_if.run_cnt, 2);
    check("ge_2_stable", bus_if.stable, 0);
    idle();
    tick();
    check("ge_3_run_cnt", bus_if.run_cnt, 3);
    check("ge_3_stable", bus_if.stable, 1);
    check("ge_3_rise", bus_if.rise, 1);

    // Break the run, then true samples separated by 5 idle cycles
    send(8'd0, 8'd1, CMP_GE);
    tick();
    check("gap_false_raw_q", bus_if.raw_q, 0);
    idle();
    tick();
    check("gap_clr_run_cnt", bus_if.run_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      send(8'd5, 8'd5, CMP_GE);
      tick();
      idle();
      repeat (5) tick();
      check($sformatf("gap_run_cnt_%0d", k), bus_if.run_cnt, k);
    end
    check("gap_stable", bus_if.stable, 1);
    check("gap_rise_gone", bus_if.rise, 0);

    // Reset while stable with a sample present
    rst = 1'b1;
    send(8'd5, 8'd5, CMP_GE);
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    send(8'd1, 8'd2, CMP_LT);
    tick();
    check("post_rst_raw_q", bus_if.raw_q, 1);
    idle();
    tick();
    check("post_rst_run_cnt", bus_if.run_cnt, 1);
    check("post_rst_stable", bus_if.stable, 0);

    // Extreme operands and a reserved mode
    send(8'd0, 8'd255, CMP_LT);
    tick();
    check("ext_lt_0_255", bus_if.raw_q, 1);
    send(8'd255, 8'd0, CMP_GT);
    tick();
    check("ext_gt_255_0", bus_if.raw_q, 1);
    send(8'd255, 8'd0, 3'd6);
    tick();
    check("reserved_6", bus_if.raw_q, 0);
    send(8'd255, 8'd255, CMP_NE);
    tick();
    check("ext_ne_eq", bus_if.raw_q, 0);
    send(8'd255, 8'd255, CMP_LE);
    tick();
    check("ext_le_eq", bus_if.raw_q, 1);
    send(8'd255, 8'd0, CMP_LT);
    tick();
    check("ext_lt_255_0", bus_if.raw_q, 0);
    send(8'd0, 8'd255, CMP_GE);
    tick();
    check("ext_ge_0_255", bus_if.raw_q, 0);
    idle();
    tick();

`ifdef CMP_SIGNED_EN
    // Signed LT: -128 < 1; switching to unsigned is a mode change and false
    bus_if.is_signed = 1'b1;
    send(8'h80, 8'h01, CMP_LT);
    tick();
    check("signed_lt_raw_q", bus_if.raw_q, 1);
    tick();
    check("signed_chg_run_cnt", bus_if.run_cnt, 0);
    idle();
    tick();
    check("signed_run_cnt", bus_if.run_cnt, 1);
    bus_if.is_signed = 1'b0;
    send(8'h80, 8'h01, CMP_LT);
    tick();
    check("unsigned_lt_raw_q", bus_if.raw_q, 0);
    idle();
    tick();
    check("unsigned_run_cnt", bus_if.run_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mag_compare_filt.md
MAG_COMPARE_FILT -- requirements
Module: mag_compare_filt

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter STABLE_CYCLES, default 3, consecutive true samples required before stable asserts; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a, b and mode are sampled on this cycle.
REQ-006 a  input  WIDTH  left operand.
REQ-007 b  input  WIDTH  right operand.
REQ-008 mode  input  3  comparison select: 0 LT, 1 LE, 2 EQ, 3 NE, 4 GT, 5 GE, 6 and 7 reserved.
REQ-009 raw_q  output  1  registered result of the most recent valid sample.
REQ-010 raw_valid  output  1  one-cycle pulse; raw_q was updated at the last edge.
REQ-011 stable  output  1  high while the saturating run counter equals STABLE_CYCLES.
REQ-012 rise  output  1  one-cycle pulse on the cycle stable goes 0 to 1.
REQ-013 run_cnt  output  8  current run count, zero-extended.

Function
REQ-014 Stage 1: on an edge with in_valid=1, raw_q takes the mode result for (a, b) and raw_valid is set to 1; with in_valid=0, raw_q holds and raw_valid is 0.
REQ-015 Comparison is unsigned unless signed mode is enabled (REQ-027); reserved modes always yield 0.
REQ-016 Stage 2: on an edge with raw_valid=1, run_cnt increments when raw_q=1 (saturating at STABLE_CYCLES) and clears to 0 when raw_q=0; with raw_valid=0, run_cnt holds.
REQ-017 stable = (run_cnt == STABLE_CYCLES), registered alongside run_cnt.
REQ-018 Latency: in_valid sample at edge n gives raw_q after edge n and run_cnt/stable after edge n+1.
REQ-019 rise is 1 for exactly the cycle after the edge where stable changes from 0 to 1; it never repeats while stable remains high.
REQ-020 Mode change: a valid sample whose mode differs from the previously sampled mode forces run_cnt to 0 at the stage-2 update for that sample, whatever its result.
REQ-021 Gaps in in_valid do not break a run; only a false valid sample or a mode change clears it.
REQ-022 With STABLE_CYCLES=1, stable follows raw_q one edge later for every valid sample.
REQ-023 Operands at their extremes (0 and 2^WIDTH-1) compare correctly; no overflow paths exist.

Reset
REQ-024 While rst=1 at an edge: raw_q=0, raw_valid=0, run_cnt=0, stable=0, rise=0, and the stored previous mode is 3'd0.
REQ-025 rst takes precedence over in_valid on the same edge; a sample presented during reset is discarded.
REQ-026 Reset during a run clears the run; after release, a full STABLE_CYCLES of true samples is again required.

Configuration
REQ-027 Macro CMP_SIGNED_EN: when defined, an input port is_signed (1 bit) is added and sampled with in_valid; is_signed=1 compares a and b as two's complement. When undefined, the port is absent and all compares are unsigned.
REQ-028 With CMP_SIGNED_EN defined, a change of is_signed between valid samples is treated as a mode change (REQ-020).

Structure
REQ-029 Package cmp_pkg holds the mode encoding constants (CMP_LT..CMP_GE) and the mode field width.
REQ-030 Sub-module stab_counter implements REQ-016/017/019 (inputs: sample valid, sample value, clear; outputs: count, stable, rise) and is parametrised by STABLE_CYCLES.

Verification
REQ-031 WIDTH=8, STABLE=3, mode LT, a=3 b=7 valid on 3 consecutive cycles -> raw_q=1 after the 1st edge; stable=1 and rise pulses once after the 4th edge; run_cnt=3.
REQ-032 Same run, 4th sample a=9 b=7 -> raw_q=0, then run_cnt=0 and stable=0 on the next edge, no rise.
REQ-033 Mode EQ with a=b=255 for 2 samples, then mode changes to GE with a=b=255 -> run_cnt is 0 after the mode change, and stable asserts only after 3 further GE samples.
REQ-034 True samples separated by 5 idle cycles each -> run_cnt counts 1,2,3 across the gaps; stable=1.
REQ-035 rst asserted with stable=1 and in_valid=1 -> all outputs 0 after the edge; the first post-reset true sample gives run_cnt=1.
REQ-036 CMP_SIGNED_EN defined, mode LT, a=8'h80 b=8'h01: is_signed=1 gives raw_q=1; is_signed=0 gives raw_q=0 and clears run_cnt.
